// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared opcodes, phase constants and state type for the phase sequencer
package phase_sequencer_pkg;

   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_ST  = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ALU = 2'b11;

   localparam logic [3:0] ALU_IN  = 4'b1100;
   localparam logic [3:0] ALU_OUT = 4'b1101;
   localparam logic [3:0] ALU_HLT = 4'b1111;

   localparam int PHASE_IDLE = 0;
   localparam int LAST_PHASE = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_IO_WAIT,
      ST_HALTED
   } seq_state_e;

   // Arithmetic/logic ops 0000..0110 and 1000..1011 produce meaningful flags.
   function automatic logic alu_op_sets_flags(input logic [3:0] alu_op);
      return (alu_op <= 4'd6) || ((alu_op >= 4'd8) && (alu_op <= 4'd11));
   endfunction

endpackage

// File: rtl/phase_sequencer_flag_reg.sv
// rtl/phase_sequencer_flag_reg.sv - S/Z/C/V condition register, loaded at the end of phase 3
module flag_reg #(
   parameter int WORD_W  = 16,
   parameter int PHASE_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [PHASE_W-1:0] phase_i,
   input  logic [WORD_W-1:0]  instruction_i,
   input  logic [3:0]         alu_flags_i,
   output logic [3:0]         flags_o
);
   import phase_sequencer_pkg::*;

   localparam logic [PHASE_W-1:0] PH_FLAGS = PHASE_W'(LAST_PHASE - 2);

   logic [1:0] op;
   logic [3:0] alu_op;
   logic       load_en;
   logic       unused_bits;
   logic [3:0] flags_q;

   assign op          = instruction_i[WORD_W-1 -: 2];
   assign alu_op      = instruction_i[7:4];
   assign unused_bits = ^{instruction_i[WORD_W-3:8], instruction_i[3:0]};
   assign load_en     = (phase_i == PH_FLAGS) && (op == OP_ALU) && alu_op_sets_flags(alu_op);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flags_q <= '0;
      end else if (load_en) begin
         flags_q <= alu_flags_i;
      end
   end

   assign flags_o = flags_q;

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - run/stop/step phase counter with HLT detect and IN/OUT phase-4 stalls
module phase_sequencer #(
   parameter int WORD_W     = 16,
   parameter int PHASE_W    = 3,
   parameter int LAST_PHASE = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_req,
   input  logic               stop_req,
   input  logic               step_mode,
   input  logic [WORD_W-1:0]  instruction,
   input  logic               alu_s,
   input  logic               alu_z,
   input  logic               alu_c,
   input  logic               alu_v,
   input  logic               in_valid,
   input  logic               out_ready,
   output logic [PHASE_W-1:0] phase,
   output logic               S,
   output logic               Z,
   output logic               C,
   output logic               V,
   output logic               running,
   output logic               halted,
   output logic               in_ack,
   output logic               out_valid
);
   import phase_sequencer_pkg::*;

   localparam logic [PHASE_W-1:0] PH_IDLE  = PHASE_W'(PHASE_IDLE);
   localparam logic [PHASE_W-1:0] PH_FIRST = PHASE_W'(1);
   localparam logic [PHASE_W-1:0] PH_HLT   = PHASE_W'(2);
   localparam logic [PHASE_W-1:0] PH_IO    = PHASE_W'(LAST_PHASE - 1);
   localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(LAST_PHASE);

   seq_state_e         state_q;
   logic [PHASE_W-1:0] phase_q;
   logic               running_q;
   logic               halted_q;
   logic               stop_pending_q;

   logic [1:0] op;
   logic [3:0] alu_op;
   logic       is_hlt;
   logic       is_in;
   logic       is_out;
   logic       io_stall;
   logic [3:0] flags;

   assign op       = instruction[WORD_W-1 -: 2];
   assign alu_op   = instruction[7:4];
   assign is_hlt   = (op == OP_ALU) && (alu_op == ALU_HLT);
   assign is_in    = (op == OP_ALU) && (alu_op == ALU_IN);
   assign is_out   = (op == OP_ALU) && (alu_op == ALU_OUT);
   assign io_stall = (is_in && !in_valid) || (is_out && !out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         phase_q        <= PH_IDLE;
         running_q      <= 1'b0;
         halted_q       <= 1'b0;
         stop_pending_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_req) begin
                  state_q        <= ST_RUN;
                  phase_q        <= PH_FIRST;
                  running_q      <= 1'b1;
                  stop_pending_q <= stop_req;
               end
            end
            ST_RUN, ST_IO_WAIT: begin
               if (stop_req) begin
                  stop_pending_q <= 1'b1;
               end
               if ((phase_q == PH_HLT) && is_hlt) begin
                  state_q        <= ST_HALTED;
                  phase_q        <= PH_IDLE;
                  running_q      <= 1'b0;
                  halted_q       <= 1'b1;
                  stop_pending_q <= 1'b0;
               end else if ((phase_q == PH_IO) && io_stall) begin
                  state_q <= ST_IO_WAIT;
               end else if (phase_q == PH_LAST) begin
                  // A stop arriving in the last phase still counts for this boundary.
                  if (!step_mode && !stop_pending_q && !stop_req) begin
                     state_q <= ST_RUN;
                     phase_q <= PH_FIRST;
                  end else begin
                     state_q        <= ST_IDLE;
                     phase_q        <= PH_IDLE;
                     running_q      <= 1'b0;
                     stop_pending_q <= 1'b0;
                  end
               end else begin
                  state_q <= ST_RUN;
                  phase_q <= phase_q + PHASE_W'(1);
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_IDLE;
               phase_q <= PH_IDLE;
            end
         endcase
      end
   end

   flag_reg #(
      .WORD_W  (WORD_W),
      .PHASE_W (PHASE_W)
   ) u_flag_reg (
      .clk_i         (clk),
      .rst_i         (rst),
      .phase_i       (phase_q),
      .instruction_i (instruction),
      .alu_flags_i   ({alu_s, alu_z, alu_c, alu_v}),
      .flags_o       (flags)
   );

   assign {S, Z, C, V} = flags;
   assign phase        = phase_q;
   assign running      = running_q;
   assign halted       = halted_q;
   assign in_ack       = running_q && (phase_q == PH_IO) && is_in && in_valid;
   assign out_valid    = running_q && (phase_q == PH_IO) && is_out;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_req;
   logic        stop_req;
   logic        step_mode;
   logic [15:0] instruction;
   logic        alu_s, alu_z, alu_c, alu_v;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  phase;
   logic        S, Z, C, V;
   logic        running;
   logic        halted;
   logic        in_ack;
   logic        out_valid;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_bad = 0;

   phase_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .run_req     (run_req),
      .stop_req    (stop_req),
      .step_mode   (step_mode),
      .instruction (instruction),
      .alu_s       (alu_s),
      .alu_z       (alu_z),
      .alu_c       (alu_c),
      .alu_v       (alu_v),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .phase       (phase),
      .S           (S),
      .Z           (Z),
      .C           (C),
      .V           (V),
      .running     (running),
      .halted      (halted),
      .in_ack      (in_ack),
      .out_valid   (out_valid)
   );

   assign flags = {S, Z, C, V};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: pulses drop just after the edge, outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      run_req  = 1'b0;
      stop_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_to_phase(input int last);
      for (int p = 1; p <= last; p++) begin
         step();
         check_eq($sformatf("phase_seq_%0d", p), 32'(phase), 32'(p));
      end
   endtask

   initial begin
      rst = 1'b1; run_req = 1'b0; stop_req = 1'b0; step_mode = 1'b0;
      instruction = 16'hC010;
      {alu_s, alu_z, alu_c, alu_v} = 4'b1010;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      check_eq("rst_phase", 32'(phase), 0);
      check_eq("rst_flags", 32'(flags), 0);
      check_eq("rst_running", 32'(running), 0);
      check_eq("rst_halted", 32'(halted), 0);
      check_eq("rst_in_ack", 32'(in_ack), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);

      // Free-running ADD
      rst = 1'b0; run_req = 1'b1;
      step();
      check_eq("add_p1", 32'(phase), 1);
      check_eq("add_running", 32'(running), 1);
      step();
      check_eq("add_p2", 32'(phase), 2);
      run_req = 1'b1;
      step();
      check_eq("add_p3_run_ignored", 32'(phase), 3);
      check_eq("add_flags_before", 32'(flags), 0);
      step();
      check_eq("add_p4", 32'(phase), 4);
      check_eq("add_flags_after", 32'(flags), 32'hA);
      step();
      check_eq("add_p5", 32'(phase), 5);
      step();
      check_eq("add_wrap_p1", 32'(phase), 1);
      step();
      check_eq("add_wrap_p2", 32'(phase), 2);
      stop_req = 1'b1;
      run_to_phase(0);
      step(); check_eq("stop_p3", 32'(phase), 3);
      check_eq("stop_still_running", 32'(running), 1);
      step(); check_eq("stop_p4", 32'(phase), 4);
      step(); check_eq("stop_p5", 32'(phase), 5);
      step();
      check_eq("stop_idle_phase", 32'(phase), 0);
      check_eq("stop_idle_running", 32'(running), 0);
      step();
      check_eq("stop_stays_idle", 32'(phase), 0);

      // Single-step mode, twice
      step_mode = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         run_req = 1'b1;
         run_to_phase(5);
         step();
         check_eq($sformatf("step%0d_end_phase", rep), 32'(phase), 0);
         check_eq($sformatf("step%0d_end_running", rep), 32'(running), 0);
      end

      // run_req with stop_req in IDLE: exactly one instruction
      step_mode = 1'b0; run_req = 1'b1; stop_req = 1'b1;
      run_to_phase(5);
      step();
      check_eq("runstop_end_phase", 32'(phase), 0);

      // HLT
      instruction = 16'hC0F0; run_req = 1'b1;
      run_to_phase(2);
      step();
      check_eq("hlt_phase", 32'(phase), 0);
      check_eq("hlt_halted", 32'(halted), 1);
      check_eq("hlt_running", 32'(running), 0);
      run_req = 1'b1;
      step(); step();
      check_eq("hlt_run_ignored_phase", 32'(phase), 0);
      check_eq("hlt_run_ignored_halted", 32'(halted), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("hlt_rst_halted", 32'(halted), 0);
      check_eq("hlt_rst_flags", 32'(flags), 0);

      // IN with a 4-cycle stall
      instruction = 16'hC0C0; step_mode = 1'b1; in_valid = 1'b0; run_req = 1'b1;
      run_to_phase(4);
      check_eq("in_ack_wait0", 32'(in_ack), 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check_eq($sformatf("in_hold_phase_%0d", i), 32'(phase), 4);
         check_eq($sformatf("in_hold_running_%0d", i), 32'(running), 1);
         check_eq($sformatf("in_hold_ack_%0d", i), 32'(in_ack), 0);
      end
      in_valid = 1'b1;
      #1;
      check_eq("in_ack_pulse", 32'(in_ack), 1);
      check_eq("in_ack_phase", 32'(phase), 4);
      step();
      check_eq("in_after_phase", 32'(phase), 5);
      check_eq("in_after_ack", 32'(in_ack), 0);
      in_valid = 1'b0;
      step();
      check_eq("in_end_phase", 32'(phase), 0);

      // IN with data already present: no stall
      in_valid = 1'b1; run_req = 1'b1;
      run_to_phase(4);
      check_eq("in_nostall_ack", 32'(in_ack), 1);
      step();
      check_eq("in_nostall_p5", 32'(phase), 5);
      in_valid = 1'b0;
      step();

      // OUT with out_ready after 3 cycles, stop recorded mid-stall
      instruction = 16'hC0D0; step_mode = 1'b0; out_ready = 1'b0; run_req = 1'b1;
      run_to_phase(4);
      check_eq("out_valid_0", 32'(out_valid), 1);
      step();
      check_eq("out_hold_phase_1", 32'(phase), 4);
      check_eq("out_valid_1", 32'(out_valid), 1);
      stop_req = 1'b1;
      step();
      check_eq("out_hold_phase_2", 32'(phase), 4);
      check_eq("out_valid_2", 32'(out_valid), 1);
      out_ready = 1'b1;
      #1;
      check_eq("out_valid_3", 32'(out_valid), 1);
      step();
      check_eq("out_after_phase", 32'(phase), 5);
      check_eq("out_after_valid", 32'(out_valid), 0);
      out_ready = 1'b0;
      step();
      check_eq("out_stop_phase", 32'(phase), 0);
      check_eq("out_stop_running", 32'(running), 0);

      // CMP loads Z; IN/OUT above left flags at zero
      instruction = 16'hC050; step_mode = 1'b1;
      {alu_s, alu_z, alu_c, alu_v} = 4'b0100; run_req = 1'b1;
      run_to_phase(3);
      check_eq("cmp_flags_before", 32'(flags), 0);
      step();
      check_eq("cmp_flags_after", 32'(flags), 32'h4);
      step(); step();
      {alu_s, alu_z, alu_c, alu_v} = 4'b1111;
      step(); step();
      check_eq("flags_held_idle", 32'(flags), 32'h4);

      // LD leaves flags alone
      instruction = 16'h0000; {alu_s, alu_z, alu_c, alu_v} = 4'b0000; run_req = 1'b1;
      run_to_phase(5);
      step();
      check_eq("ld_flags_kept", 32'(flags), 32'h4);

      // Reset in phase 3 wins over the flag load
      instruction = 16'hC050; {alu_s, alu_z, alu_c, alu_v} = 4'b1111; run_req = 1'b1;
      run_to_phase(3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rst_p3_phase", 32'(phase), 0);
      check_eq("rst_p3_flags", 32'(flags), 0);
      check_eq("rst_p3_running", 32'(running), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
